// File: rtl/button_event_scheduler_pkg.sv
// Shared types for the button event scheduler: event kinds, per-button
// press-FSM state encoding and an index-width helper.
package button_event_scheduler_pkg;

   typedef enum logic {
      EVT_SHORT = 1'b0,
      EVT_LONG  = 1'b1
   } evt_type_e;

   typedef enum logic [1:0] {
      ST_WAIT_REL  = 2'd0,
      ST_IDLE      = 2'd1,
      ST_PRESSED   = 2'd2,
      ST_LONG_HELD = 2'd3
   } btn_state_e;

   // Width of an index into n items, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button_event_scheduler_if.sv
// Event stream from the scheduler to the game FSM: valid/ready with the
// button index and event kind of the head entry.
interface button_event_scheduler_if
   import button_event_scheduler_pkg::*;
#(
   parameter int N_BTN = 4
);
   localparam int BTN_W = idx_width(N_BTN);

   logic             evt_valid;
   logic             evt_ready;
   logic [BTN_W-1:0] evt_btn;
   logic             evt_type;

   modport master (output evt_valid, evt_btn, evt_type, input evt_ready);
   modport slave  (input evt_valid, evt_btn, evt_type, output evt_ready);
endinterface

// File: rtl/btn_press_fsm.sv
// One button: classifies a press as SHORT or LONG and emits a one-cycle
// request. A button already down at reset must be released before it counts.
module btn_press_fsm
   import button_event_scheduler_pkg::*;
#(
   parameter int LONG_TICKS = 1000
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      tick,
   input  logic      btn,
   output logic      req,
   output evt_type_e req_type,
   output logic      held
);
   localparam int              CNT_W    = $clog2(LONG_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LONG_TICKS);

   btn_state_e       state, state_next;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_next;

   // Next state, hold counter and request; release beats the LONG threshold.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      state_next    = state;
      hold_cnt_next = hold_cnt;
      req           = 1'b0;
      req_type      = EVT_SHORT;
      case (state)
         ST_WAIT_REL: begin
            if (!btn) state_next = ST_IDLE;
         end
         ST_IDLE: begin
            if (btn) begin
               state_next    = ST_PRESSED;
               hold_cnt_next = '0;
            end
         end
         ST_PRESSED: begin
            if (!btn) begin
               state_next = ST_IDLE;
               req        = 1'b1;
               req_type   = EVT_SHORT;
            end else if (tick) begin
               if (hold_cnt == CNT_LAST) begin
                  state_next = ST_LONG_HELD;
                  req        = 1'b1;
                  req_type   = EVT_LONG;
               end
               if (hold_cnt != CNT_MAX) hold_cnt_next = hold_cnt + 1'b1;
            end
         end
         ST_LONG_HELD: begin
            if (!btn) state_next = ST_IDLE;
         end
         default: state_next = ST_WAIT_REL;
      endcase
   end

   // State register; held reflects the state entered at this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      if (!rst_n) begin
         state    <= ST_WAIT_REL;
         hold_cnt <= '0;
         held     <= 1'b0;
      end else begin
         state    <= state_next;
         hold_cnt <= hold_cnt_next;
         held     <= (state_next == ST_PRESSED) || (state_next == ST_LONG_HELD);
      end
   end
endmodule

// File: rtl/button_event_scheduler.sv
// Top level: hold-time prescaler, per-button press FSMs, pending-event
// latches, round-robin arbiter and a first-word-fall-through event FIFO.
module button_event_scheduler
   import button_event_scheduler_pkg::*;
#(
   parameter int N_BTN      = 4,
   parameter int TICK_DIV   = 50000,
   parameter int LONG_TICKS = 1000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_BTN-1:0]         btn_db,
   button_event_scheduler_if.master evt,
   output logic [N_BTN-1:0]         held,
   output logic                     overflow
);
   localparam int BTN_W = idx_width(N_BTN);
   localparam int PRE_W = idx_width(TICK_DIV);
   localparam int PTR_W = idx_width(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [BTN_W-1:0] btn;
      evt_type_e        kind;
   } evt_t;

   logic [PRE_W-1:0] pre_cnt;
   logic             tick;

   assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

   // Free-running prescaler; tick marks the wrap cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    pre_cnt <= '0;
      else if (tick) pre_cnt <= '0;
      else           pre_cnt <= pre_cnt + 1'b1;
   end

   logic [N_BTN-1:0] req;
   evt_type_e        req_type [N_BTN];

   for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      btn_press_fsm #(.LONG_TICKS(LONG_TICKS)) u_fsm (
         .clk      (clk),
         .rst_n    (rst_n),
         .tick     (tick),
         .btn      (btn_db[g]),
         .req      (req[g]),
         .req_type (req_type[g]),
         .held     (held[g])
      );
   end

   logic [N_BTN-1:0] pend, grant;
   evt_type_e        ptype [N_BTN];
   logic [BTN_W-1:0] rr_ptr, grant_idx, scan_idx;
   logic             grant_vld;
   logic [CNT_W-1:0] fifo_cnt;

   // Round-robin grant: first pending button at or after rr_ptr, wrapping.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      grant     = '0;
      scan_idx  = '0;
      if (fifo_cnt < CNT_W'(FIFO_DEPTH)) begin
         for (int k = 0; k < N_BTN; k++) begin
            scan_idx = BTN_W'((int'(rr_ptr) + k) % N_BTN);
            if (!grant_vld && pend[scan_idx]) begin
               grant_vld       = 1'b1;
               grant_idx       = scan_idx;
               grant[scan_idx] = 1'b1;
            end
         end
      end
   end

   // Pending latches: a request into an occupied slot is dropped and flagged,
   // even when that slot is being granted this same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend     <= '0;
         rr_ptr   <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < N_BTN; i++) ptype[i] <= EVT_SHORT;
      end else begin
         pend     <= (pend & ~grant) | (req & ~pend);
         overflow <= |(req & pend);
         for (int i = 0; i < N_BTN; i++) begin
            if (req[i] && !pend[i]) ptype[i] <= req_type[i];
         end
         if (grant_vld) begin
            rr_ptr <= (grant_idx == BTN_W'(N_BTN - 1)) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   evt_t             mem [FIFO_DEPTH];
   evt_t             head;
   logic             push, pop, fifo_valid;

   assign fifo_valid = (fifo_cnt != '0);
   assign push       = grant_vld;
   assign pop        = fifo_valid & evt.evt_ready;

   // FIFO pointers and occupancy; push and pop may both happen in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // FIFO storage write port.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; occupancy is tracked by fifo_cnt and the
      // outputs are gated by it, so stale contents are never visible.
      if (push) mem[wr_ptr] <= '{btn: grant_idx, kind: ptype[grant_idx]};
   end

   assign head          = mem[rd_ptr];
   assign evt.evt_valid = fifo_valid;
   assign evt.evt_btn   = fifo_valid ? head.btn : '0;
   assign evt.evt_type  = fifo_valid && (head.kind == EVT_LONG);
endmodule

// File: tb/tb_button_event_scheduler.sv
// Self-checking bench: directed press scenarios plus randomized button and
// ready activity, compared every cycle against a behavioural event model.
module tb_button_event_scheduler;
   localparam int N_BTN      = 4;
   localparam int TICK_DIV   = 4;
   localparam int LONG_TICKS = 10;
   localparam int FIFO_DEPTH = 4;

   typedef int int_q_t[$];

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N_BTN-1:0] btn_db;
   logic [N_BTN-1:0] held;
   logic             overflow;

   button_event_scheduler_if #(.N_BTN(N_BTN)) evt_if ();

   button_event_scheduler #(
      .N_BTN      (N_BTN),
      .TICK_DIV   (TICK_DIV),
      .LONG_TICKS (LONG_TICKS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_db   (btn_db),
      .evt      (evt_if),
      .held     (held),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Behavioural model: events are encoded as btn*2 + type (type 1 = LONG).
   bit [N_BTN-1:0] m_armed, m_pressed, m_long, m_pend, m_ptype;
   int             m_ticks [N_BTN];
   int             m_rr, m_pre;
   int             m_fifo[$];
   bit             m_ovf;
   logic [N_BTN-1:0] m_held;

   int dut_log[$];
   int ovf_cnt;

   task automatic model_reset();
      m_armed = '0; m_pressed = '0; m_long = '0; m_pend = '0; m_ptype = '0;
      for (int i = 0; i < N_BTN; i++) m_ticks[i] = 0;
      m_rr = 0; m_pre = 0; m_ovf = 1'b0; m_held = '0;
      m_fifo.delete();
   endtask

   task automatic model_step();
      bit             tick;
      bit [N_BTN-1:0] req, rtype, pend_old;
      int             g;
      tick  = (m_pre == TICK_DIV - 1);
      m_pre = tick ? 0 : m_pre + 1;
      req   = '0;
      rtype = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (!m_armed[i]) begin
            if (!btn_db[i]) m_armed[i] = 1'b1;
         end else if (!m_pressed[i]) begin
            if (btn_db[i]) begin
               m_pressed[i] = 1'b1; m_ticks[i] = 0; m_long[i] = 1'b0;
            end
         end else if (!btn_db[i]) begin
            m_pressed[i] = 1'b0;
            if (!m_long[i]) req[i] = 1'b1;
         end else if (tick) begin
            m_ticks[i]++;
            if (m_ticks[i] == LONG_TICKS && !m_long[i]) begin
               m_long[i] = 1'b1; req[i] = 1'b1; rtype[i] = 1'b1;
            end
         end
         m_held[i] = m_pressed[i];
      end
      pend_old = m_pend;
      g = -1;
      if (m_fifo.size() < FIFO_DEPTH) begin
         for (int k = 0; k < N_BTN; k++) begin
            int idx = (m_rr + k) % N_BTN;
            if (g < 0 && m_pend[idx]) g = idx;
         end
      end
      if (m_fifo.size() != 0 && evt_if.evt_ready) void'(m_fifo.pop_front());
      if (g >= 0) begin
         m_fifo.push_back(g * 2 + int'(m_ptype[g]));
         m_pend[g] = 1'b0;
         m_rr      = (g + 1) % N_BTN;
      end
      m_ovf = |(req & pend_old);
      for (int i = 0; i < N_BTN; i++) begin
         if (req[i] && !pend_old[i]) begin
            m_pend[i] = 1'b1; m_ptype[i] = rtype[i];
         end
      end
   endtask

   always @(posedge clk) begin
      if (rst_n) model_step();
   end

   // Per-cycle comparison on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         check("evt_valid", 32'(evt_if.evt_valid), 32'(m_fifo.size() != 0));
         if (m_fifo.size() != 0)
            check("evt_head", 32'({evt_if.evt_btn, evt_if.evt_type}), m_fifo[0]);
         check("held", 32'(held), 32'(m_held));
         check("overflow", 32'(overflow), 32'(m_ovf));
         if (overflow) ovf_cnt++;
         if (evt_if.evt_valid && evt_if.evt_ready)
            dut_log.push_back(int'(evt_if.evt_btn) * 2 + int'(evt_if.evt_type));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check_log(input string tag, input int_q_t exp);
      check({tag, " count"}, dut_log.size(), exp.size());
      for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
         check($sformatf("%s event %0d", tag, i), dut_log[i], exp[i]);
   endtask

   task automatic tap(input int b);
      btn_db[b] = 1'b1;
      step(3);
      btn_db[b] = 1'b0;
      step(3);
   endtask

   initial begin
      int_q_t e;
      bit     found;
      rst_n = 1'b0;
      btn_db = 4'b0001;
      evt_if.evt_ready = 1'b1;
      ovf_cnt = 0;
      model_reset();
      #1;
      check("reset evt_valid", 32'(evt_if.evt_valid), 32'd0);
      check("reset evt_btn", 32'(evt_if.evt_btn), 32'd0);
      check("reset held", 32'(held), 32'd0);
      check("reset overflow", 32'(overflow), 32'd0);

      // 1: held through reset -> ignored; later 5-tick press -> one SHORT
      step(3);
      rst_n = 1'b1;
      step(10);
      btn_db[0] = 1'b0; step(5);
      btn_db[0] = 1'b1; step(5 * TICK_DIV);
      btn_db[0] = 1'b0; step(8);
      e = '{0};
      check_log("s1", e);

      // 2: 15-tick hold of btn2 -> LONG while held, nothing on release
      dut_log.delete();
      btn_db[2] = 1'b1; step(15 * TICK_DIV);
      check("s2 held", 32'(held), 32'b0100);
      btn_db[2] = 1'b0; step(8);
      e = '{5};
      check_log("s2", e);

      // 3: release btn1 exactly at its 10th tick -> SHORT wins
      dut_log.delete();
      btn_db[1] = 1'b1;
      found = 1'b0;
      for (int n = 0; n < 200 && !found; n++) begin
         step(1);
         if (m_ticks[1] == LONG_TICKS - 1 && m_pre == TICK_DIV - 1) found = 1'b1;
      end
      check("s3 boundary reached", 32'(found), 32'd1);
      btn_db[1] = 1'b0; step(8);
      e = '{2};
      check_log("s3", e);

      // 4: simultaneous release of all buttons with rr_ptr at 2
      dut_log.delete();
      btn_db = 4'b1111; step(8);
      btn_db = 4'b0000; step(10);
      e = '{4, 6, 0, 2};
      check_log("s4", e);

      // 5: fill FIFO, park one in pend, overflow on another, then drain
      dut_log.delete();
      ovf_cnt = 0;
      evt_if.evt_ready = 1'b0;
      for (int b = 0; b < N_BTN; b++) tap(b);
      tap(0);
      check("s5 full valid", 32'(evt_if.evt_valid), 32'd1);
      check("s5 no overflow yet", ovf_cnt, 0);
      tap(0);
      check("s5 overflow pulses", ovf_cnt, 1);
      evt_if.evt_ready = 1'b1; step(12);
      e = '{0, 2, 4, 6, 0};
      check_log("s5", e);

      // 6: async reset mid-press with events queued
      dut_log.delete();
      evt_if.evt_ready = 1'b0;
      tap(1); tap(3);
      btn_db[2] = 1'b1; step(5);
      check("s6 queued valid", 32'(evt_if.evt_valid), 32'd1);
      check("s6 held before", 32'(held), 32'b0100);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("s6 async evt_valid", 32'(evt_if.evt_valid), 32'd0);
      check("s6 async held", 32'(held), 32'd0);
      step(2);
      rst_n = 1'b1;
      step(10);
      btn_db[2] = 1'b0;
      evt_if.evt_ready = 1'b1;
      step(10);
      e = {};
      check_log("s6 stale", e);
      tap(2); step(4);
      e = '{4};
      check_log("s6 after", e);

      // 7: randomized buttons and consumer stalls against the model
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N_BTN; i++)
            if ($urandom_range(0, 59) == 0) btn_db[i] = ~btn_db[i];
         evt_if.evt_ready = ($urandom_range(0, 3) != 0);
         step(1);
      end
      btn_db = '0;
      evt_if.evt_ready = 1'b1;
      step(30);
      check("final drained", 32'(evt_if.evt_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
